// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                            |
// | Function : Load-use / branch-flush / dmem-wait sequencing for a 5-stage    |
// |            pipeline, with saturating stall and flush counters.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                 c_REM_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_REM_W-1:0] c_FLUSH_INIT = c_REM_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_REM_W-1:0] r_flush_rem, w_flush_rem_nxt;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

  logic w_load_use, w_mem_stall;
  logic w_freeze, w_flush_step, w_run_rules;
  logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_write, w_id_ex_flush, w_hold;

  assign w_load_use  = memread_ex && (rd_ex != 5'd0) &&
                       ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
  assign w_mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_flush_rem <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_rem <= w_flush_rem_nxt;
    end
  end

  always_comb begin
    w_freeze        = 1'b0;
    w_flush_step    = 1'b0;
    w_run_rules     = 1'b0;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_write   = 1'b1;
    w_id_ex_flush   = 1'b0;
    w_hold          = 1'b0;
    w_state_nxt     = ST_RUN;
    w_flush_rem_nxt = r_flush_rem;

    // Classify the cycle first; the action for each class is shared by all states.
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) w_freeze    = 1'b1;
        else             w_run_rules = 1'b1;
      end
      ST_FLUSH: begin
        if (w_mem_stall) w_freeze     = 1'b1;
        else             w_flush_step = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready)               w_freeze     = 1'b1;
        else if (r_flush_rem != '0)    w_flush_step = 1'b1;
        else                           w_run_rules  = 1'b1;
      end
      default: ;
    endcase

    if (w_freeze) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_write = 1'b0;
      w_hold        = 1'b1;
      w_state_nxt   = ST_MEM_WAIT;
    end else if (w_flush_step) begin
      w_if_id_flush   = 1'b1;
      w_id_ex_flush   = 1'b1;
      w_flush_rem_nxt = r_flush_rem - c_REM_W'(1);
      w_state_nxt     = (r_flush_rem == c_REM_W'(1)) ? ST_RUN : ST_FLUSH;
    end else if (w_run_rules) begin
      if (branch_taken_ex) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_flush_rem_nxt = c_FLUSH_INIT;
          w_state_nxt     = ST_FLUSH;
        end
      end else if (w_load_use) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_id_ex_flush = 1'b1;
      end
    end
  end

  // Reset forces a bubble into ID/EX and a NOP into IF/ID while the PC holds.
  assign pc_write    = reset_n  & w_pc_write;
  assign if_id_write = reset_n  & w_if_id_write;
  assign if_id_flush = !reset_n | w_if_id_flush;
  assign id_ex_write = !reset_n | w_id_ex_write;
  assign id_ex_flush = !reset_n | w_id_ex_flush;
  assign ex_mem_hold = reset_n  & w_hold;
  assign state       = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (id_ex_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipeline_hazard_ctrl                                         |
// | Function : Bench for pipeline_hazard_ctrl; two instances (3-cycle flush,   |
// |            4-bit counters / 1-cycle flush, 16-bit counters) vs a model.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, memread_ex, branch_taken_ex;
  logic       dmem_req, dmem_ready, perf_clr;

  logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_flush_a, ex_mem_hold_a;
  logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_flush_b, ex_mem_hold_b;
  logic [1:0]  state_a, state_b;
  logic [3:0]  stall_cnt_a, flush_cnt_a;
  logic [15:0] stall_cnt_b, flush_cnt_b;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
    .id_ex_write(id_ex_write_a), .id_ex_flush(id_ex_flush_a), .ex_mem_hold(ex_mem_hold_a),
    .state(state_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
    .id_ex_write(id_ex_write_b), .id_ex_flush(id_ex_flush_b), .ex_mem_hold(ex_mem_hold_b),
    .state(state_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // Control bundle: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_hold, state}
  logic [7:0]  obs[2];
  logic [15:0] obs_st[2], obs_fl[2];
  assign obs[0] = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_flush_a, ex_mem_hold_a, state_a};
  assign obs[1] = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_flush_b, ex_mem_hold_b, state_b};
  assign obs_st[0] = {12'd0, stall_cnt_a};
  assign obs_fl[0] = {12'd0, flush_cnt_a};
  assign obs_st[1] = stall_cnt_b;
  assign obs_fl[1] = flush_cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed, whether a dmem access is pending, counters.
  int         fc[2]   = '{3, 1};
  int         cmax[2] = '{15, 65535};
  int         m_rem[2], n_rem[2], m_stall[2], m_flush[2];
  bit         m_wait[2], n_wait[2];
  logic [7:0] exp_ctl[2];

  task automatic eval();
    bit         lu, fr;
    logic [5:0] ctl;
    logic [1:0] st;
    lu = memread_ex && (rd_ex != 0) &&
         ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
    for (int i = 0; i < 2; i++) begin
      n_rem[i]  = m_rem[i];
      n_wait[i] = 1'b0;
      if (!reset_n) begin
        m_rem[i] = 0; m_wait[i] = 1'b0; m_stall[i] = 0; m_flush[i] = 0; n_rem[i] = 0;
        exp_ctl[i] = 8'b00111000;
      end else begin
        fr = m_wait[i] ? !dmem_ready : (dmem_req && !dmem_ready);
        st = m_wait[i] ? 2'd2 : ((m_rem[i] != 0) ? 2'd1 : 2'd0);
        if (fr) begin
          ctl = 6'b000001; n_wait[i] = 1'b1;
        end else if (m_rem[i] > 0) begin
          ctl = 6'b111110; n_rem[i] = m_rem[i] - 1;
        end else if (branch_taken_ex) begin
          ctl = 6'b111110; n_rem[i] = fc[i] - 1;
        end else if (lu) ctl = 6'b000110;
        else             ctl = 6'b110100;
        exp_ctl[i] = {ctl, st};
      end
    end
  endtask

  task automatic commit();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset_n) begin
        if (perf_clr) begin
          m_stall[i] = 0; m_flush[i] = 0;
        end else begin
          if (!exp_ctl[i][7] && m_stall[i] < cmax[i]) m_stall[i]++;
          if (exp_ctl[i][3]  && m_flush[i] < cmax[i]) m_flush[i]++;
        end
        m_rem[i]  = n_rem[i];
        m_wait[i] = n_wait[i];
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rs1_id = 5'd1; rs2_id = 5'd2; rd_ex = 5'd9;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; memread_ex = 1'b0; branch_taken_ex = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    memread_ex = 1'b1; rd_ex = 5'd2; use_rs2_id = 1'b1; branch_taken_ex = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); eval();
      checks++;
      if (obs[0] !== 8'b00111000) begin errors++; $display("FAIL reset_ctl got %b exp 00111000", obs[0]); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_st[i] !== 16'd0 || obs_fl[i] !== 16'd0) begin
          errors++; $display("FAIL reset_cnt[%0d] got %0d/%0d exp 0/0", i, obs_st[i], obs_fl[i]);
        end
      end
      commit();
    end
    reset_n = 1'b1;
    set_idle();
  endtask

  task automatic test_load_use();
    set_idle();
    memread_ex = 1'b1; rd_ex = 5'd5; use_rs2_id = 1'b1; rs2_id = 5'd5; use_rs1_id = 1'b1; rs1_id = 5'd6;
    @(negedge clk); eval();
    checks++;
    if (obs[1] !== 8'b00011000) begin errors++; $display("FAIL load_use_ctl got %b exp 00011000", obs[1]); end
    commit();
    set_idle();
    @(negedge clk); eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== exp_ctl[i]) begin errors++; $display("FAIL load_use_after[%0d] got %b exp %b", i, obs[i], exp_ctl[i]); end
      checks++;
      if (obs_st[i] !== 16'd1 || obs_fl[i] !== 16'd1) begin
        errors++; $display("FAIL load_use_cnt[%0d] got %0d/%0d exp 1/1", i, obs_st[i], obs_fl[i]);
      end
    end
    commit();
  endtask

  task automatic test_x0();
    set_idle();
    memread_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1;
    @(negedge clk); eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 8'b11010000) begin errors++; $display("FAIL x0_exempt[%0d] got %b exp 11010000", i, obs[i]); end
    end
    commit();
    set_idle();
  endtask

  task automatic test_branch_flush();
    int sq[6] = '{0, 1, 1, 0, 0, 0};
    int fl[6] = '{1, 1, 1, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      set_idle();
      branch_taken_ex = (k == 0);
      if (k == 1) begin memread_ex = 1'b1; rd_ex = 5'd1; use_rs1_id = 1'b1; branch_taken_ex = 1'b1; end
      @(negedge clk); eval();
      checks++;
      if (state_a !== 2'(sq[k]) || id_ex_flush_a !== 1'(fl[k]) || if_id_flush_a !== 1'(fl[k])) begin
        errors++; $display("FAIL branch_seq step %0d got st=%0d fl=%b%b exp st=%0d fl=%0d", k, state_a, if_id_flush_a, id_ex_flush_a, sq[k], fl[k]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_ctl[i]) begin errors++; $display("FAIL branch_ctl[%0d] step %0d got %b exp %b", i, k, obs[i], exp_ctl[i]); end
        checks++;
        if (obs_fl[i] !== 16'(m_flush[i])) begin errors++; $display("FAIL branch_fcnt[%0d] got %0d exp %0d", i, obs_fl[i], m_flush[i]); end
      end
      commit();
    end
  endtask

  task automatic test_mem_wait();
    set_idle(); perf_clr = 1'b1;
    @(negedge clk); eval(); commit();
    for (int k = 0; k < 6; k++) begin
      set_idle();
      dmem_req = (k < 5); dmem_ready = (k >= 4);
      @(negedge clk); eval();
      checks++;
      if ((k < 4) !== (ex_mem_hold_b && !id_ex_write_b)) begin
        errors++; $display("FAIL mem_freeze step %0d got hold=%b idw=%b exp freeze=%0d", k, ex_mem_hold_b, id_ex_write_b, k < 4);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_ctl[i]) begin errors++; $display("FAIL mem_ctl[%0d] step %0d got %b exp %b", i, k, obs[i], exp_ctl[i]); end
      end
      commit();
    end
    @(negedge clk); eval();
    checks++;
    if (obs_st[1] !== 16'd4) begin errors++; $display("FAIL mem_stall_cnt got %0d exp 4", obs_st[1]); end
    commit();
  endtask

  task automatic test_priority();
    for (int k = 0; k < 6; k++) begin
      set_idle();
      if (k < 3) begin
        memread_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; use_rs1_id = 1'b1;
        branch_taken_ex = 1'b1; dmem_req = 1'b1; dmem_ready = (k == 2);
      end
      @(negedge clk); eval();
      if (k == 0) begin
        checks++;
        if (obs[1] !== 8'b00000100) begin errors++; $display("FAIL prio_freeze got %b exp 00000100", obs[1]); end
      end
      if (k == 2) begin
        checks++;
        if (obs[1] !== 8'b11111010) begin errors++; $display("FAIL prio_release got %b exp 11111010", obs[1]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_ctl[i]) begin errors++; $display("FAIL prio_ctl[%0d] step %0d got %b exp %b", i, k, obs[i], exp_ctl[i]); end
      end
      commit();
    end
  endtask

  task automatic test_saturate_reset();
    set_idle();
    memread_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); eval(); commit();
    end
    @(negedge clk); eval();
    checks++;
    if (obs_st[0] !== 16'd15 || obs_fl[0] !== 16'd15) begin
      errors++; $display("FAIL sat_cnt got %0d/%0d exp 15/15", obs_st[0], obs_fl[0]);
    end
    checks++;
    if (obs_st[1] !== 16'(m_stall[1])) begin errors++; $display("FAIL sat_cnt_b got %0d exp %0d", obs_st[1], m_stall[1]); end
    commit();
    set_idle(); branch_taken_ex = 1'b1;
    @(negedge clk); eval(); commit();
    set_idle();
    @(negedge clk); eval(); commit();
    reset_n = 1'b0;
    #1;
    checks++;
    if (state_a !== 2'd0 || stall_cnt_a !== 4'd0 || flush_cnt_a !== 4'd0) begin
      errors++; $display("FAIL async_reset got st=%0d cnt=%0d/%0d exp 0 0/0", state_a, stall_cnt_a, flush_cnt_a);
    end
    @(negedge clk); eval(); commit();
    reset_n = 1'b1;
    memread_ex = 1'b1; rd_ex = 5'd4; rs2_id = 5'd4; use_rs2_id = 1'b1;
    @(negedge clk); eval(); commit();
    memread_ex = 1'b1; perf_clr = 1'b1;
    @(negedge clk); eval(); commit();
    set_idle();
    @(negedge clk); eval();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_st[i] !== 16'd0 || obs_fl[i] !== 16'd0) begin
        errors++; $display("FAIL clr_wins[%0d] got %0d/%0d exp 0/0", i, obs_st[i], obs_fl[i]);
      end
    end
    commit();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_ex           = 5'($urandom_range(0, 3));
      use_rs1_id      = 1'($urandom_range(0, 1));
      use_rs2_id      = 1'($urandom_range(0, 1));
      memread_ex      = ($urandom_range(0, 99) < 40);
      branch_taken_ex = ($urandom_range(0, 99) < 15);
      dmem_req        = ($urandom_range(0, 99) < 30);
      dmem_ready      = ($urandom_range(0, 99) < 55);
      perf_clr        = ($urandom_range(0, 99) < 2);
      @(negedge clk); eval();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_ctl[i]) begin errors++; $display("FAIL rand_ctl[%0d] cyc %0d got %b exp %b", i, k, obs[i], exp_ctl[i]); end
        checks++;
        if (obs_st[i] !== 16'(m_stall[i]) || obs_fl[i] !== 16'(m_flush[i])) begin
          errors++; $display("FAIL rand_cnt[%0d] cyc %0d got %0d/%0d exp %0d/%0d", i, k, obs_st[i], obs_fl[i], m_stall[i], m_flush[i]);
        end
      end
      commit();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_wait[i] = 1'b0; m_stall[i] = 0; m_flush[i] = 0;
    end
    test_reset();
    test_load_use();
    test_x0();
    test_branch_flush();
    test_mem_wait();
    test_priority();
    test_saturate_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
